// File: rtl/rf_wp_arbiter.sv
// rtl/rf_wp_arbiter.sv - register-file write-port arbiter between the pipeline and a long-latency unit
module rf_wp_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        p_we,
    input  logic [4:0]  p_wa,
    input  logic [31:0] p_wd,
    input  logic        m_valid,
    input  logic [4:0]  m_wa,
    input  logic [31:0] m_wd,
    output logic        m_ready,
    output logic        pipe_stall,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd
);

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } state_t;

    // Last blocked-cycle count before the long-latency unit is forced through
    localparam logic [3:0] CNT_LAST = 4'(STARVE_MAX - 1);

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic        p_req;
    logic        m_zero;

    // A write to r0 is meaningless: pipeline r0 writes are not requests,
    // long-latency r0 writes are accepted and dropped.
    assign p_req  = p_we && (p_wa != 5'd0);
    assign m_zero = (m_wa == 5'd0);

    // Stall is a pure decode of the state register so it never glitches on inputs
    assign pipe_stall = (state_q == FORCE);

    // Grant selection and zero-latency steering onto the register-file port
    always_comb begin
        m_ready = 1'b0;
        rf_we   = 1'b0;
        rf_wa   = 5'd0;
        rf_wd   = 32'd0;
        if (rstn) begin
            if (state_q == FORCE) begin
                // Pipeline is frozen this cycle; only the long-latency unit may write
                m_ready = m_valid;
                if (m_valid && !m_zero) begin
                    rf_we = 1'b1;
                    rf_wa = m_wa;
                    rf_wd = m_wd;
                end
            end else if (p_req) begin
                rf_we   = 1'b1;
                rf_wa   = p_wa;
                rf_wd   = p_wd;
                // An r0 write needs no port, so it is accepted alongside the pipeline
                m_ready = m_valid && m_zero;
            end else if (m_valid) begin
                m_ready = 1'b1;
                if (!m_zero) begin
                    rf_we = 1'b1;
                    rf_wa = m_wa;
                    rf_wd = m_wd;
                end
            end
        end
    end

    // Next state and starvation counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            NORMAL: begin
                if (m_valid && m_ready) begin
                    cnt_d = 4'd0;
                end else if (m_valid) begin
                    if (cnt_q >= CNT_LAST) begin
                        state_d = FORCE;
                    end
                    if (cnt_q != 4'hF) begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            FORCE: begin
                // Forced grant lasts exactly one cycle, taken or not
                state_d = NORMAL;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = NORMAL;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and counter registers with asynchronous reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= NORMAL;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_rf_wp_arbiter.sv
// tb/tb_rf_wp_arbiter.sv - directed self-checking bench for rf_wp_arbiter
module tb_rf_wp_arbiter;

    logic        clk;
    logic        rstn;
    logic        p_we;
    logic [4:0]  p_wa;
    logic [31:0] p_wd;
    logic        m_valid;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    logic        m_ready;
    logic        pipe_stall;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    int n_checks = 0;
    int n_fail   = 0;

    rf_wp_arbiter #(.STARVE_MAX(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .p_we       (p_we),
        .p_wa       (p_wa),
        .p_wd       (p_wd),
        .m_valid    (m_valid),
        .m_wa       (m_wa),
        .m_wd       (m_wd),
        .m_ready    (m_ready),
        .pipe_stall (pipe_stall),
        .rf_we      (rf_we),
        .rf_wa      (rf_wa),
        .rf_wd      (rf_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where new inputs are applied
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic pwe, input logic [4:0] pwa, input logic [31:0] pwd,
                         input logic mv, input logic [4:0] mwa, input logic [31:0] mwd);
        p_we = pwe; p_wa = pwa; p_wd = pwd;
        m_valid = mv; m_wa = mwa; m_wd = mwd;
        #1;
    endtask

    initial begin
        rstn = 1'b0;
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h99);
        chk("rst_stall", {31'd0, pipe_stall}, 32'd0);
        chk("rst_m_ready", {31'd0, m_ready}, 32'd0);
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        next_cycle();
        next_cycle();
        rstn = 1'b1;

        // Idle port
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("idle_rf_we", {31'd0, rf_we}, 32'd0);
        chk("idle_rf_wa", {27'd0, rf_wa}, 32'd0);
        chk("idle_m_ready", {31'd0, m_ready}, 32'd0);

        // Pipeline alone
        next_cycle();
        drive(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0);
        chk("p_only_rf_we", {31'd0, rf_we}, 32'd1);
        chk("p_only_rf_wa", {27'd0, rf_wa}, 32'd5);
        chk("p_only_rf_wd", rf_wd, 32'h11);
        chk("p_only_m_ready", {31'd0, m_ready}, 32'd0);

        // Long-latency unit alone
        next_cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hABCD);
        chk("m_only_rf_we", {31'd0, rf_we}, 32'd1);
        chk("m_only_rf_wa", {27'd0, rf_wa}, 32'd7);
        chk("m_only_rf_wd", rf_wd, 32'hABCD);
        chk("m_only_m_ready", {31'd0, m_ready}, 32'd1);

        // Starvation: four blocked cycles then one forced grant
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h99);
            chk($sformatf("starve%0d_stall", i), {31'd0, pipe_stall}, 32'd0);
            chk($sformatf("starve%0d_rf_wa", i), {27'd0, rf_wa}, 32'd3);
            chk($sformatf("starve%0d_m_ready", i), {31'd0, m_ready}, 32'd0);
        end
        next_cycle();
        chk("force_stall", {31'd0, pipe_stall}, 32'd1);
        chk("force_rf_wa", {27'd0, rf_wa}, 32'd9);
        chk("force_rf_wd", rf_wd, 32'h99);
        chk("force_m_ready", {31'd0, m_ready}, 32'd1);
        next_cycle();
        drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
        chk("post_force_stall", {31'd0, pipe_stall}, 32'd0);
        chk("post_force_rf_wa", {27'd0, rf_wa}, 32'd3);

        // r0 write from the long-latency unit is accepted beside the pipeline
        next_cycle();
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd0, 32'h55);
        chk("mzero_m_ready", {31'd0, m_ready}, 32'd1);
        chk("mzero_rf_we", {31'd0, rf_we}, 32'd1);
        chk("mzero_rf_wa", {27'd0, rf_wa}, 32'd4);
        chk("mzero_rf_wd", rf_wd, 32'h44);

        // Pipeline r0 write is not a request
        next_cycle();
        drive(1'b1, 5'd0, 32'h77, 1'b1, 5'd6, 32'h66);
        chk("pzero_rf_we", {31'd0, rf_we}, 32'd1);
        chk("pzero_rf_wa", {27'd0, rf_wa}, 32'd6);
        chk("pzero_m_ready", {31'd0, m_ready}, 32'd1);

        // Forced cycle with m_valid dropped: no write, still one cycle only
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h99);
        end
        chk("drop_pre_stall", {31'd0, pipe_stall}, 32'd0);
        next_cycle();
        drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd9, 32'h99);
        chk("drop_stall", {31'd0, pipe_stall}, 32'd1);
        chk("drop_rf_we", {31'd0, rf_we}, 32'd0);
        chk("drop_m_ready", {31'd0, m_ready}, 32'd0);
        next_cycle();
        chk("drop_after_stall", {31'd0, pipe_stall}, 32'd0);
        chk("drop_after_rf_wa", {27'd0, rf_wa}, 32'd3);

        // Reset asserted in the middle of a forced cycle
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h99);
        end
        next_cycle();
        chk("rf_force_stall", {31'd0, pipe_stall}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("rf_stall", {31'd0, pipe_stall}, 32'd0);
        chk("rf_m_ready", {31'd0, m_ready}, 32'd0);
        chk("rf_rf_we", {31'd0, rf_we}, 32'd0);
        next_cycle();
        rstn = 1'b1;
        #1;
        // Counter restarts at 0: four blocked cycles again before the forced grant
        for (int i = 0; i < 4; i++) begin
            if (i > 0) next_cycle();
            chk($sformatf("rel%0d_stall", i), {31'd0, pipe_stall}, 32'd0);
            chk($sformatf("rel%0d_rf_wa", i), {27'd0, rf_wa}, 32'd3);
            chk($sformatf("rel%0d_m_ready", i), {31'd0, m_ready}, 32'd0);
        end
        next_cycle();
        chk("rel_force_stall", {31'd0, pipe_stall}, 32'd1);
        chk("rel_force_rf_wa", {27'd0, rf_wa}, 32'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
